// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM command sequencer: state encoding
// and default data-path widths.
package ram_ctrl_pkg;

    localparam int RAM_ADDR_WIDTH = 6;
    localparam int RAM_DATA_WIDTH = 8;
    localparam int STATE_WIDTH    = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RSP     = 3'd4
    } state_t;

endpackage

// File: rtl/ram_cmd_ctrl.sv
// Sequences read/write commands into the latched-address RAM protocol.
// Optional RAM_CTRL_ADDR_CACHE_EN skips the address-latch cycle on a repeat address.
module ram_cmd_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_y,
    output logic                  busy
);

    state_t                  state_r;
    logic                    write_r;
    logic                    ram_we_r;
    logic [ADDR_WIDTH-1:0]   ram_addr_r;
    logic [DATA_WIDTH-1:0]   ram_data_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;
`ifdef RAM_CTRL_ADDR_CACHE_EN
    logic                    cache_valid_r;
`endif

    // ram_addr_r only changes when a command leaves IDLE, so in IDLE it is
    // always the address the RAM last latched.
    // Command sequencing FSM with registered RAM-side and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            write_r       <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= {ADDR_WIDTH{1'b0}};
            ram_data_r    <= {DATA_WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
`ifdef RAM_CTRL_ADDR_CACHE_EN
            cache_valid_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        write_r    <= cmd_write;
                        ram_addr_r <= cmd_addr;
                        if (cmd_write) begin
                            ram_data_r <= cmd_wdata;
                        end
`ifdef RAM_CTRL_ADDR_CACHE_EN
                        if (cache_valid_r && (cmd_addr == ram_addr_r)) begin
                            state_r  <= cmd_write ? ST_WRITE : ST_CAPTURE;
                            ram_we_r <= cmd_write;
                        end else begin
                            state_r  <= ST_LATCH;
                        end
`else
                        state_r <= ST_LATCH;
`endif
                    end
                end
                ST_LATCH: begin
`ifdef RAM_CTRL_ADDR_CACHE_EN
                    cache_valid_r <= 1'b1;
`endif
                    if (write_r) begin
                        state_r  <= ST_WRITE;
                        ram_we_r <= 1'b1;
                    end else begin
                        state_r  <= ST_CAPTURE;
                    end
                end
                ST_WRITE: begin
                    ram_we_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                ST_CAPTURE: begin
                    rsp_rdata_r <= ram_y;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    ram_we_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign ram_we    = ram_we_r;
    assign ram_addr  = ram_addr_r;
    assign ram_data  = ram_data_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Scoreboard bench for ram_cmd_ctrl with a behavioural latched-address RAM.
// Build with RAM_CTRL_ADDR_CACHE_EN defined to exercise the cache-hit timing.
module tb_ram_cmd_ctrl;
    import ram_ctrl_pkg::*;

    localparam int AW = 6;
    localparam int DW = 8;
`ifdef RAM_CTRL_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_y;
    logic          busy;

    ram_cmd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_y(ram_y), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ev = 0;

    always @(posedge clk) ev <= ev + 1;

    // RAM: latches the address while we is low, writes into the latched address when high.
    logic [DW-1:0] mem [64];
    logic [AW-1:0] lat;
    always @(posedge clk) begin
        if (ram_we) mem[lat] <= ram_data;
        else        lat      <= ram_addr;
    end
    assign ram_y = mem[lat];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    exp_t          wq[$];
    exp_t          rq[$];
    logic [DW-1:0] model_mem [64];
    logic [AW-1:0] m_last;
    bit            m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic          prev_valid;
    logic          prev_ready;
    logic [DW-1:0] prev_rdata;

    always @(negedge clk) begin : monitor
        exp_t x;
        if (rst_n) begin
            if (ram_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_we", 32'd1, 32'd0);
                end else begin
                    x = wq.pop_front();
                    check("we_cycle", ev, x.at);
                    check("we_addr", 32'(ram_addr), 32'(x.addr));
                    check("we_data", 32'(ram_data), 32'(x.data));
                end
            end
            if (rsp_valid && !prev_valid) begin
                if (rq.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
                else                check("rsp_first_cycle", ev, rq[0].at);
            end
            if (prev_valid && !prev_ready) begin
                check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
                check("rsp_rdata_hold", 32'(rsp_rdata), 32'(prev_rdata));
            end
            if (rsp_valid && rsp_ready && rq.size() > 0) begin
                x = rq.pop_front();
                check("rsp_data", 32'(rsp_rdata), 32'(x.data));
            end
            prev_valid <= rsp_valid;
        end else begin
            prev_valid <= 1'b0;
        end
        prev_ready <= rsp_ready;
        prev_rdata <= rsp_rdata;
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit chk_ready);
        bit   h;
        int   k;
        int   n;
        exp_t x;
        h = CACHE && m_valid && (a == m_last);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
        k = ev + 1;
        x.addr = a;
        if (w) begin
            x.data = d;
            x.at   = h ? k : k + 1;
            wq.push_back(x);
            model_mem[a] = d;
        end else begin
            x.data = model_mem[a];
            x.at   = h ? k + 1 : k + 2;
            rq.push_back(x);
        end
        m_last  = a;
        m_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (chk_ready) begin
            n = 0;
            @(negedge clk);
            while (!cmd_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check(w ? "wr_ready_cycle" : "rd_ready_cycle", ev,
                  w ? (h ? k + 1 : k + 2) : (h ? k + 2 : k + 3));
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        m_last = '0; m_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (5) begin
            @(negedge clk);
            check("idle_we", 32'(ram_we), 32'd0);
            check("idle_addr", 32'(ram_addr), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
            check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        check("reset_rdata", 32'(rsp_rdata), 32'd0);

        send(1'b1, 6'd5, 8'h3C, 1'b1);
        send(1'b0, 6'd5, 8'h00, 1'b1);

        send(1'b1, 6'd9, 8'hA5, 1'b1);
        send(1'b1, 6'd9, 8'h5A, 1'b1);
        send(1'b0, 6'd9, 8'h00, 1'b1);

        // Response back-pressure on address 63.
        send(1'b1, 6'd63, 8'h77, 1'b1);
        @(posedge clk); #1 rsp_ready = 1'b0;
        send(1'b0, 6'd63, 8'h00, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rsp_timeout", 32'd0, 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("bp_ready_low", 32'(cmd_ready), 32'd0);
            check("bp_valid", 32'(rsp_valid), 32'd1);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_still_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("bp_ready_back", 32'(cmd_ready), 32'd1);

        // Reset during the LATCH cycle of a write must suppress the write.
        send(1'b1, 6'd7, 8'h11, 1'b1);
        send(1'b1, 6'd8, 8'h22, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd7; cmd_wdata = 8'hFF;
        @(negedge clk);
        check("abort_accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("abort_busy_latch", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_last  = '0;
        @(negedge clk);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'd0);
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        send(1'b0, 6'd7, 8'h00, 1'b1);

        for (int a = 0; a < 64; a++) send(1'b1, 6'(a), 8'(a), 1'b1);
        for (int a = 0; a < 64; a++) send(1'b0, 6'(a), 8'h00, 1'b1);

        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(rq.size() + wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
